count_ctrl: RTL and testbench
=============================

COUNT_CTRL -- requirements
Module: count_ctrl

Interface
REQ-001 Parameter: WIDTH, default 5, bit width of all count values; SHALL match the WIDTH of the downstream loadable counter.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 start  input  1  request a count run; sampled only in IDLE.
REQ-005 start_val  input  WIDTH  initial count; captured on an accepted start.
REQ-006 end_val  input  WIDTH  terminal count; captured on an accepted start.
REQ-007 hold  input  1  pause request; suppresses counting while high.
REQ-008 abort  input  1  cancel the current run.
REQ-009 cnt_out  input  WIDTH  current value fed back from the counter.
REQ-010 load  output  1  counter load strobe.
REQ-011 enab  output  1  counter increment enable.
REQ-012 cnt_in  output  WIDTH  counter load value.
REQ-013 busy  output  1  run in progress.
REQ-014 done  output  1  one-cycle completion pulse.

Function
REQ-015 The FSM SHALL have four states: IDLE, LOAD, RUN and DONE.
REQ-016 IDLE with start=1: SHALL capture start_val into start_reg and end_val into end_reg, then go to LOAD.
REQ-017 IDLE with start=0: SHALL stay in IDLE.
REQ-018 start outside IDLE SHALL be ignored, and start_reg/end_reg SHALL NOT change.
REQ-019 LOAD: load=1, enab=0; the state SHALL go to RUN next cycle.
REQ-020 cnt_in SHALL equal start_reg in all states.
REQ-021 RUN with cnt_out==end_reg: enab=0; the state SHALL go to DONE next cycle.
REQ-022 RUN with cnt_out!=end_reg: enab=!hold; the state SHALL stay in RUN.
REQ-023 enab and load SHALL be combinational decodes of state, hold and cnt_out (no added latency).
REQ-024 Count arithmetic SHALL be modulo 2^WIDTH; end_reg<start_reg SHALL wrap through 0.
REQ-025 The number of enab-high cycles in a run SHALL equal (end_reg-start_reg) mod 2^WIDTH.
REQ-026 start_reg==end_reg SHALL give zero enab cycles: LOAD, then one RUN cycle, then DONE.
REQ-027 DONE: done=1 for exactly one cycle, then the state SHALL return to IDLE.
REQ-028 A new start SHALL be accepted no earlier than the cycle after DONE.
REQ-029 busy SHALL be 1 in LOAD and RUN, and 0 in IDLE and DONE.
REQ-030 abort=1 in LOAD or RUN: load=0 and enab=0 that cycle, next state IDLE, and no done pulse.
REQ-031 abort SHALL take priority over terminal-count detection in the same cycle.
REQ-032 abort in IDLE or DONE SHALL have no effect.
REQ-033 hold in LOAD SHALL NOT suppress load.
REQ-034 hold in RUN at terminal count SHALL NOT delay the transition to DONE.
REQ-035 load and enab SHALL never both be 1 in the same cycle.

Reset
REQ-036 rst=1 at a clock edge SHALL force state=IDLE and start_reg=end_reg=0.
REQ-037 After reset: load=0, enab=0, cnt_in=0, busy=0, done=0.
REQ-038 rst SHALL override start, abort and hold in the same cycle.
REQ-039 rst mid-run SHALL produce no done pulse.

Structure
REQ-040 State encodings (IDLE=0, LOAD=1, RUN=2, DONE=3) SHALL live in the shared package count_ctrl_pkg as named constants, with a 2-bit state width constant.
REQ-041 The default WIDTH value SHALL also live in count_ctrl_pkg, for reuse by the counter and the bench.
REQ-042 count_ctrl SHALL be a single module with no sub-modules.
REQ-043 The counter SHALL NOT be instantiated inside count_ctrl; integration wires load, enab, cnt_in and cnt_out at the level above.
REQ-044 The verification harness SHALL connect count_ctrl to the actual counter block.

Verification
REQ-045 start_val=3, end_val=7, hold=0: load high 1 cycle after start; enab high 4 cycles; cnt_out reaches 7; done pulses 1 cycle later; busy=0 thereafter.
REQ-046 WIDTH=5, start_val=30, end_val=2: exactly 4 enab cycles (30->31->0->1->2); done asserted once.
REQ-047 start_val=end_val=9: zero enab cycles; done 3 cycles after start accepted; cnt_out stays 9.
REQ-048 start 0->5 with hold=1 for 3 cycles after the second increment: enab low exactly 3 cycles; total run 3 cycles longer; final cnt_out=5.
REQ-049 abort in RUN at cnt_out=2 (target 6): enab=0 same cycle; IDLE next cycle; no done; a start pulse issued during RUN is ignored.
REQ-050 rst=1 mid-run: next edge gives all outputs 0 and IDLE; a fresh start completes normally.

Source files
------------

// File: rtl/count_ctrl_pkg.sv
// Shared constants for the count controller, its loadable counter and the bench.
//   STATE_W       : width of the controller state encoding
//   DEFAULT_WIDTH : default count width shared by controller and counter
//   state_e       : controller states (IDLE=0, LOAD=1, RUN=2, DONE=3)
package count_ctrl_pkg;

  localparam int unsigned STATE_W       = 2;
  localparam int unsigned DEFAULT_WIDTH = 5;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage : count_ctrl_pkg

// File: rtl/count_ctrl_counter.sv
// Loadable up-counter driven by count_ctrl; wired alongside it at the level above.
//   clk, rst  : clock, synchronous active-high reset
//   load      : load cnt_in into the counter (wins over enab)
//   enab      : increment by one, modulo 2^WIDTH
//   cnt_in    : load value
//   cnt_out   : current count
module count_ctrl_counter
  import count_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             enab,
  input  logic [WIDTH-1:0] cnt_in,
  output logic [WIDTH-1:0] cnt_out
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next count: load has priority, increment wraps naturally
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = cnt_in;
    end else if (enab) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_out = cnt_q;

endmodule : count_ctrl_counter

// File: rtl/count_ctrl.sv
// Run controller for an external loadable counter: loads start_val, then
// enables increments until the fed-back count reaches end_val.
//   clk, rst             : clock, synchronous active-high reset
//   start                : run request, honoured only in IDLE
//   start_val, end_val   : run bounds, captured on an accepted start
//   hold                 : pause counting while high (RUN only)
//   abort                : cancel a run in LOAD/RUN, no done pulse
//   cnt_out              : count fed back from the counter
//   load, enab           : counter strobes, decoded from state/hold/cnt_out
//   cnt_in               : counter load value (captured start_val)
//   busy                 : high in LOAD and RUN
//   done                 : one-cycle pulse in DONE
module count_ctrl
  import count_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] start_val,
  input  logic [WIDTH-1:0] end_val,
  input  logic             hold,
  input  logic             abort,
  input  logic [WIDTH-1:0] cnt_out,
  output logic             load,
  output logic             enab,
  output logic [WIDTH-1:0] cnt_in,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] start_reg_q, start_reg_d;
  logic [WIDTH-1:0] end_reg_q, end_reg_d;

  // Next state, bound capture and counter strobes
  always_comb begin
    state_d     = state_q;
    start_reg_d = start_reg_q;
    end_reg_d   = end_reg_q;
    load        = 1'b0;
    enab        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          start_reg_d = start_val;
          end_reg_d   = end_val;
          state_d     = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          load    = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // abort outranks terminal-count detection
        if (abort) begin
          state_d = ST_IDLE;
        end else if (cnt_out == end_reg_q) begin
          state_d = ST_DONE;
        end else begin
          enab = ~hold;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      start_reg_q <= '0;
      end_reg_q   <= '0;
    end else begin
      state_q     <= state_d;
      start_reg_q <= start_reg_d;
      end_reg_q   <= end_reg_d;
    end
  end

  // Status outputs are pure decodes of flops
  assign cnt_in = start_reg_q;
  assign busy   = (state_q == ST_LOAD) || (state_q == ST_RUN);
  assign done   = (state_q == ST_DONE);

endmodule : count_ctrl

// File: tb/tb_count_ctrl.sv
// Directed bench: count_ctrl wired to its loadable counter.
module tb_count_ctrl;
  import count_ctrl_pkg::*;

  localparam int unsigned W = DEFAULT_WIDTH;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] start_val;
  logic [W-1:0] end_val;
  logic         hold;
  logic         abort;
  logic [W-1:0] cnt_out;
  logic         load;
  logic         enab;
  logic [W-1:0] cnt_in;
  logic         busy;
  logic         done;

  int n_checks = 0;
  int n_pass   = 0;

  count_ctrl #(.WIDTH(W)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .start_val (start_val),
    .end_val   (end_val),
    .hold      (hold),
    .abort     (abort),
    .cnt_out   (cnt_out),
    .load      (load),
    .enab      (enab),
    .cnt_in    (cnt_in),
    .busy      (busy),
    .done      (done)
  );

  count_ctrl_counter #(.WIDTH(W)) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .enab    (enab),
    .cnt_in  (cnt_in),
    .cnt_out (cnt_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Step past the next rising edge; inputs are driven after this, outputs sampled 1 later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full run with optional hold window; hold is always high during LOAD.
  task automatic run(input logic [W-1:0] sv, input logic [W-1:0] ev, input int exp_en,
                     input int hold_at, input int hold_len, input bit hold_all,
                     input string tag);
    int n_en, n_stall, n_it, n_held, exp_stall;
    bit got_done, both;
    n_en = 0; n_stall = 0; n_it = 0; n_held = 0; got_done = 0; both = 0;
    exp_stall = (hold_at >= 0) ? hold_len : 0;
    start = 1'b1; start_val = sv; end_val = ev; hold = 1'b0; abort = 1'b0;
    tick();
    start = 1'b0; start_val = '0; end_val = '0; hold = 1'b1;
    #1;
    check_eq({tag, ":load"},   32'(load),   32'd1);
    check_eq({tag, ":ld_en"},  32'(enab),   32'd0);
    check_eq({tag, ":ld_bsy"}, 32'(busy),   32'd1);
    check_eq({tag, ":cnt_in"}, 32'(cnt_in), 32'(sv));
    while (!got_done && n_it < 100) begin
      tick();
      n_it++;
      hold = hold_all || (hold_at >= 0 && n_en >= hold_at && n_held < hold_len);
      #1;
      if (done) begin
        got_done = 1'b1;
      end else begin
        if (load && enab) both = 1'b1;
        if (enab) n_en++;
        else if (cnt_out != ev) n_stall++;
        if (hold && cnt_out != ev) n_held++;
      end
    end
    check_eq({tag, ":done_seen"}, 32'(got_done), 32'd1);
    check_eq({tag, ":enab_cyc"},  32'(n_en),     32'(exp_en));
    check_eq({tag, ":stall_cyc"}, 32'(n_stall),  32'(exp_stall));
    check_eq({tag, ":run_len"},   32'(n_it),     32'(exp_en + 2 + exp_stall));
    check_eq({tag, ":final_cnt"}, 32'(cnt_out),  32'(ev));
    check_eq({tag, ":dn_busy"},   32'(busy),     32'd0);
    check_eq({tag, ":ld_and_en"}, 32'(both),     32'd0);
    // start and abort in DONE must be ignored
    hold = 1'b0; start = 1'b1; start_val = ~sv; end_val = ~ev; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    #1;
    check_eq({tag, ":post_busy"}, 32'(busy),   32'd0);
    check_eq({tag, ":post_done"}, 32'(done),   32'd0);
    check_eq({tag, ":post_cin"},  32'(cnt_in), 32'(sv));
  endtask

  initial begin
    int n_it;
    bit hit;
    rst = 1'b1; start = 1'b1; abort = 1'b1; hold = 1'b1;
    start_val = 5'd7; end_val = 5'd7;

    // Reset overrides start/abort/hold
    tick();
    tick();
    start = 1'b0; abort = 1'b0; hold = 1'b0;
    #1;
    check_eq("rst:load",   32'(load),   32'd0);
    check_eq("rst:enab",   32'(enab),   32'd0);
    check_eq("rst:cnt_in", 32'(cnt_in), 32'd0);
    check_eq("rst:busy",   32'(busy),   32'd0);
    check_eq("rst:done",   32'(done),   32'd0);
    rst = 1'b0;
    tick();
    #1;
    check_eq("idle:busy", 32'(busy), 32'd0);

    run(5'd3,  5'd7, 4, -1, 0, 1'b0, "basic");
    run(5'd30, 5'd2, 4, -1, 0, 1'b0, "wrap");
    run(5'd9,  5'd9, 0, -1, 0, 1'b1, "equal");
    run(5'd0,  5'd5, 5,  2, 3, 1'b0, "hold");

    // Abort in RUN at cnt_out=2 with a stray start issued mid-run
    start = 1'b1; start_val = 5'd0; end_val = 5'd6;
    tick();
    start = 1'b0; start_val = '0; end_val = '0;
    n_it = 0; hit = 1'b0;
    while (!hit && n_it < 20) begin
      tick();
      n_it++;
      if (cnt_out == 5'd1) begin
        start = 1'b1; start_val = 5'd20; end_val = 5'd25;
      end else begin
        start = 1'b0;
      end
      abort = (cnt_out == 5'd2);
      #1;
      if (abort) hit = 1'b1;
    end
    check_eq("abort:reached", 32'(hit),  32'd1);
    check_eq("abort:enab",    32'(enab), 32'd0);
    check_eq("abort:load",    32'(load), 32'd0);
    tick();
    abort = 1'b0; start = 1'b0;
    #1;
    check_eq("abort:busy",   32'(busy),    32'd0);
    check_eq("abort:done",   32'(done),    32'd0);
    check_eq("abort:cnt_in", 32'(cnt_in),  32'd0);
    check_eq("abort:cnt",    32'(cnt_out), 32'd2);
    tick();
    #1;
    check_eq("abort:done2", 32'(done), 32'd0);

    // Abort at terminal count wins over DONE
    start = 1'b1; start_val = 5'd1; end_val = 5'd1;
    tick();
    start = 1'b0;
    tick();
    abort = 1'b1;
    #1;
    check_eq("abtc:enab", 32'(enab), 32'd0);
    tick();
    abort = 1'b0;
    #1;
    check_eq("abtc:done", 32'(done), 32'd0);
    check_eq("abtc:busy", 32'(busy), 32'd0);

    // Abort in IDLE is ignored; then reset mid-run
    start = 1'b1; abort = 1'b1; start_val = 5'd3; end_val = 5'd20;
    tick();
    start = 1'b0; abort = 1'b0;
    #1;
    check_eq("idab:load", 32'(load), 32'd1);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check_eq("mrst:load",   32'(load),    32'd0);
    check_eq("mrst:enab",   32'(enab),    32'd0);
    check_eq("mrst:cnt_in", 32'(cnt_in),  32'd0);
    check_eq("mrst:busy",   32'(busy),    32'd0);
    check_eq("mrst:done",   32'(done),    32'd0);
    check_eq("mrst:cnt",    32'(cnt_out), 32'd0);
    tick();
    #1;
    check_eq("mrst:done2", 32'(done), 32'd0);
    run(5'd4, 5'd6, 2, -1, 0, 1'b0, "fresh");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_count_ctrl
